tb_irq_stim_monitor: RTL and testbench

Parametrised end-of-test monitor and random interrupt stimulus generator for the e203 Verilator bench. It snoops the commit stage and decode handshake, counts cycles and retired instructions, detects the tohost loop, renders a pass/fail/timeout verdict, and drives NUM_IRQ independent pseudo-random interrupt lines. Each line asserts after a random gap and holds until its handler PC commits. It sits beside the SoC top in the bench and replaces ad-hoc initial/forever stimulus with synthesizable, Verilator-friendly logic.

---
 rtl/tb_irq_stim_monitor.sv | 199 +++++++++++++++++++
 tb/tb_tb_irq_stim_monitor.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_irq_stim_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_stim_monitor
//  Description : End-of-test monitor (cycle/instruction/tohost-hit counters,
//                pass/fail/timeout verdict) plus NUM_IRQ independent
//                pseudo-random interrupt stimulus channels with ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_stim_monitor #(
   parameter int          NUM_IRQ     = 3,
   parameter int          PC_W        = 32,
   parameter int          CNT_W       = 32,
   parameter int          GAP_W       = 10,
   parameter int          TIMEOUT_BIT = 20,
   parameter int          END_HITS    = 8,
   parameter int          STOP_HITS   = 32,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmt_valid,
   input  logic [PC_W-1:0]         cmt_pc,
   input  logic                    i_valid,
   input  logic                    i_ready,
   input  logic [31:0]             x3,
   input  logic                    inj_en,
   input  logic                    timeout_en,
   input  logic [PC_W-1:0]         pc_tohost,
   input  logic [PC_W-1:0]         pc_arm,
   input  logic [NUM_IRQ*PC_W-1:0] pc_ack,
   output logic [NUM_IRQ-1:0]      irq_o,
   output logic [CNT_W-1:0]        cycle_cnt,
   output logic [CNT_W-1:0]        instr_cnt,
   output logic [CNT_W-1:0]        end_cycle,
   output logic [CNT_W-1:0]        hits,
   output logic                    done,
   output logic                    pass,
   output logic                    timeout
);

   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_end_hits  = CNT_W'(END_HITS);
   localparam logic [CNT_W-1:0] c_stop_hits = CNT_W'(STOP_HITS);
   localparam logic [GAP_W:0]   c_gap_one   = (GAP_W+1)'(1);

   // Per-channel stimulus states
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ASSERT = 2'd2;
   localparam logic [1:0] S_HALT   = 2'd3;

   logic [CNT_W-1:0] cycle_cnt_q;
   logic [CNT_W-1:0] instr_cnt_q;
   logic [CNT_W-1:0] end_cycle_q;
   logic [CNT_W-1:0] hits_q;
   logic             hit_seen_q;
   logic             armed_q;
   logic             done_q;
   logic             pass_q;
   logic             timeout_q;

   logic w_hit;
   logic w_arm;
   logic w_stop;

   assign w_hit  = cmt_valid & (cmt_pc == pc_tohost);
   assign w_arm  = cmt_valid & (cmt_pc == pc_arm);
   // Injection stops for good once the test is decided, the hit budget is
   // exceeded, or the bench withdraws the global enable.
   assign w_stop = done_q | timeout_q | (hits_q > c_stop_hits) | ~inj_en;

   // Cycle, instruction and tohost-hit bookkeeping plus the arm latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
         end_cycle_q <= '0;
         hits_q      <= '0;
         hit_seen_q  <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + c_cnt_one;
         if (i_valid && i_ready && !hit_seen_q)
            instr_cnt_q <= instr_cnt_q + c_cnt_one;
         if (w_hit && !hit_seen_q)
            end_cycle_q <= cycle_cnt_q;
         if (w_hit && (hits_q != '1))
            hits_q <= hits_q + c_cnt_one;
         if (w_hit)
            hit_seen_q <= 1'b1;
         if (w_arm)
            armed_q <= 1'b1;
      end
   end

   // Sticky verdict: done/pass one cycle after the hit target, or watchdog
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (!done_q && !timeout_q && (hits_q >= c_end_hits)) begin
            done_q <= 1'b1;
            pass_q <= (x3 == 32'd1);
         end
         if (timeout_en && cycle_cnt_q[TIMEOUT_BIT] && !done_q)
            timeout_q <= 1'b1;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
   assign end_cycle = end_cycle_q;
   assign hits      = hits_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign timeout   = timeout_q;

   generate
      for (genvar k = 0; k < NUM_IRQ; k++) begin : g_chan
         // A zero seed would lock the LFSR, so it is nudged to 1.
         localparam logic [15:0] c_seed_raw = LFSR_SEED + 16'(k);
         localparam logic [15:0] c_seed     = (c_seed_raw == 16'd0) ? 16'd1 : c_seed_raw;

         logic [1:0]     state_q, state_d;
         logic [GAP_W:0] gap_q, gap_d;
         logic [15:0]    lfsr_q;
         logic           irq_q, irq_d;
         logic           w_ack;
         logic [GAP_W:0] w_reload;

         assign w_ack    = cmt_valid & (cmt_pc == pc_ack[k*PC_W +: PC_W]);
         assign w_reload = {1'b0, lfsr_q[GAP_W-1:0]} + c_gap_one;

         // Fibonacci LFSR (taps 16,14,13,11), free-running once armed
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               lfsr_q <= c_seed;
            else if (armed_q)
               lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         end

         // State register with gap counter and registered interrupt line
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q <= S_IDLE;
               gap_q   <= '0;
               irq_q   <= 1'b0;
            end else begin
               state_q <= state_d;
               gap_q   <= gap_d;
               irq_q   <= irq_d;
            end
         end

         // Next-state: wait a random gap, assert, hold until the handler acks
         always_comb begin
            state_d = state_q;
            gap_d   = gap_q;
            case (state_q)
               S_IDLE: begin
                  if (armed_q) begin
                     state_d = S_WAIT;
                     gap_d   = w_reload;
                  end
               end
               S_WAIT: begin
                  if (gap_q == c_gap_one)
                     state_d = w_stop ? S_HALT : S_ASSERT;
                  else
                     gap_d = gap_q - c_gap_one;
               end
               S_ASSERT: begin
                  // Stop is only honoured at the ack so the handler can finish.
                  if (w_ack) begin
                     if (w_stop) begin
                        state_d = S_HALT;
                     end else begin
                        state_d = S_WAIT;
                        gap_d   = w_reload;
                     end
                  end
               end
               default: state_d = S_HALT;
            endcase
         end

         // Output: the line follows the state being entered, so it is registered
         always_comb begin
            irq_d = (state_d == S_ASSERT);
         end

         assign irq_o[k] = irq_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tb_irq_stim_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tb_irq_stim_monitor
//  Description : Randomised self-checking bench for tb_irq_stim_monitor with a
//                time-stamp based reference model of counters and channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tb_irq_stim_monitor;

   localparam int          N   = 3;
   localparam int          PW  = 32;
   localparam int          CW  = 32;
   localparam int          GW  = 10;
   localparam int          TB  = 6;
   localparam int          EH  = 8;
   localparam int          SH  = 2;
   localparam logic [15:0] SEED      = 16'hACE1;
   localparam logic [31:0] PC_TOHOST = 32'h8000_0040;
   localparam logic [31:0] PC_ARM    = 32'h8000_0100;

   function automatic logic [31:0] ack_pc(int k);
      return 32'h8000_0200 + 32'(k) * 32'd16;
   endfunction

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmt_valid;
   logic [31:0]   cmt_pc;
   logic          i_valid;
   logic          i_ready;
   logic [31:0]   x3;
   logic          inj_en;
   logic          timeout_en;
   logic [N*PW-1:0] pc_ack;
   logic [N-1:0]  irq_o;
   logic [CW-1:0] cycle_cnt, instr_cnt, end_cycle, hits;
   logic          done, pass, timeout;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < N; k++) begin : g_ack
      assign pc_ack[k*PW +: PW] = ack_pc(k);
   end

   tb_irq_stim_monitor #(
      .NUM_IRQ(N), .PC_W(PW), .CNT_W(CW), .GAP_W(GW), .TIMEOUT_BIT(TB),
      .END_HITS(EH), .STOP_HITS(SH), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
      .i_valid(i_valid), .i_ready(i_ready), .x3(x3), .inj_en(inj_en),
      .timeout_en(timeout_en), .pc_tohost(PC_TOHOST), .pc_arm(PC_ARM),
      .pc_ack(pc_ack), .irq_o(irq_o), .cycle_cnt(cycle_cnt),
      .instr_cnt(instr_cnt), .end_cycle(end_cycle), .hits(hits),
      .done(done), .pass(pass), .timeout(timeout)
   );

   // ---------------- reference model (absolute-time based) ----------------
   logic [31:0] m_cyc, m_hits, m_end, m_instr;
   bit          m_seen, m_done, m_pass, m_to, m_armed;
   logic [15:0] m_lfsr [N];
   bit          m_irq  [N];
   bit          m_wait [N];
   bit          m_halt [N];
   int          m_dec  [N];   // edge at which a waiting channel decides
   int          m_edge;

   function automatic int gap_of(logic [15:0] l);
      return int'(l[GW-1:0]) + 1;
   endfunction

   function automatic logic [N-1:0] m_irq_vec();
      logic [N-1:0] v;
      for (int k = 0; k < N; k++) v[k] = m_irq[k];
      return v;
   endfunction

   task automatic model_reset();
      logic [15:0] s;
      m_cyc = '0; m_hits = '0; m_end = '0; m_instr = '0;
      m_seen = 0; m_done = 0; m_pass = 0; m_to = 0; m_armed = 0; m_edge = 0;
      for (int k = 0; k < N; k++) begin
         s = SEED + 16'(k);
         if (s == 16'd0) s = 16'd1;
         m_lfsr[k] = s; m_irq[k] = 0; m_wait[k] = 0; m_halt[k] = 0; m_dec[k] = 0;
      end
   endtask

   task automatic model_update();
      bit hit, stop, o_done, o_to, o_seen, o_armed;
      logic [31:0] o_cyc, o_hits;
      hit = cmt_valid && (cmt_pc == PC_TOHOST);
      o_done = m_done; o_to = m_to; o_seen = m_seen; o_armed = m_armed;
      o_cyc = m_cyc; o_hits = m_hits;
      stop = o_done || o_to || (o_hits > 32'(SH)) || !inj_en;
      m_edge++;
      for (int k = 0; k < N; k++) begin
         if (m_halt[k]) begin
         end else if (m_irq[k]) begin
            if (cmt_valid && (cmt_pc == ack_pc(k))) begin
               m_irq[k] = 0;
               if (stop) m_halt[k] = 1;
               else begin m_wait[k] = 1; m_dec[k] = m_edge + gap_of(m_lfsr[k]); end
            end
         end else if (m_wait[k]) begin
            if (m_edge == m_dec[k]) begin
               m_wait[k] = 0;
               if (stop) m_halt[k] = 1; else m_irq[k] = 1;
            end
         end else if (o_armed) begin
            m_wait[k] = 1; m_dec[k] = m_edge + gap_of(m_lfsr[k]);
         end
         if (o_armed)
            m_lfsr[k] = {m_lfsr[k][14:0], m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10]};
      end
      if (hit && (m_hits != 32'hFFFF_FFFF)) m_hits = m_hits + 32'd1;
      if (hit && !o_seen) m_end = o_cyc;
      if (hit) m_seen = 1;
      if (i_valid && i_ready && !o_seen) m_instr = m_instr + 32'd1;
      if (cmt_valid && (cmt_pc == PC_ARM)) m_armed = 1;
      if (!o_done && !o_to && (o_hits >= 32'(EH))) begin m_done = 1; m_pass = (x3 == 32'd1); end
      if (timeout_en && o_cyc[TB] && !o_done) m_to = 1;
      m_cyc = m_cyc + 32'd1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cmt_valid = 1'b0; cmt_pc = '0; i_valid = 1'b0; i_ready = 1'b0;
      x3 = '0; inj_en = 1'b0; timeout_en = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_bg();
      i_valid   = 1'($urandom_range(0, 1));
      i_ready   = 1'($urandom_range(0, 1));
      cmt_valid = 1'($urandom_range(0, 1));
      cmt_pc    = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      #1;
      n_vec++; if (irq_o !== 3'b000) begin n_err++; $display("FAIL reset_irq: got %b want 000", irq_o); end
      n_vec++; if (cycle_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cycle: got %0d want 0", cycle_cnt); end
      n_vec++; if (instr_cnt !== 32'd0) begin n_err++; $display("FAIL reset_instr: got %0d want 0", instr_cnt); end
      n_vec++; if (end_cycle !== 32'd0) begin n_err++; $display("FAIL reset_end: got %0d want 0", end_cycle); end
      n_vec++; if (hits !== 32'd0) begin n_err++; $display("FAIL reset_hits: got %0d want 0", hits); end
      n_vec++; if ({done, pass, timeout} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {done, pass, timeout}); end
   endtask

   task automatic test_no_arm();
      do_reset();
      inj_en = 1'b1;
      for (int c = 1; c <= 5000; c++) begin
         rand_bg();
         if ($urandom_range(0, 19) == 0) begin
            cmt_valid = 1'b1; cmt_pc = ack_pc(int'($urandom_range(0, N-1)));
         end
         step();
         n_vec++;
         if (irq_o !== 3'b000) begin n_err++; $display("FAIL noarm_irq: step %0d got %b want 000", c, irq_o); end
      end
      n_vec++; if (cycle_cnt !== 32'd5000) begin n_err++; $display("FAIL noarm_cycle: got %0d want 5000", cycle_cnt); end
      n_vec++; if (instr_cnt !== m_instr) begin n_err++; $display("FAIL noarm_instr: got %0d want %0d", instr_cnt, m_instr); end
   endtask

   task automatic test_pulses();
      int nrise [N];
      int first [N];
      int last  [N];
      int due   [N];
      bit ontime [N];
      logic [N-1:0] prev;
      bit fin;
      int pick;
      do_reset();
      inj_en = 1'b1;
      prev = '0;
      fin = 0;
      for (int k = 0; k < N; k++) begin nrise[k] = 0; first[k] = -1; last[k] = 0; due[k] = -1; ontime[k] = 0; end
      for (int c = 1; c <= 12000; c++) begin
         rand_bg();
         cmt_valid = 1'b0;
         if (c == 10) begin
            cmt_valid = 1'b1; cmt_pc = PC_ARM;
         end else begin
            pick = -1;
            for (int k = 0; k < N; k++)
               if (pick < 0 && due[k] >= 0 && due[k] <= c) pick = k;
            if (pick >= 0) begin
               cmt_valid = 1'b1; cmt_pc = ack_pc(pick);
               ontime[pick] = (due[pick] == c); due[pick] = -1;
            end
         end
         step();
         n_vec++;
         if (irq_o !== m_irq_vec()) begin n_err++; $display("FAIL pulse_irq: step %0d got %b want %b", c, irq_o, m_irq_vec()); end
         for (int k = 0; k < N; k++) begin
            if (!prev[k] && irq_o[k]) begin
               if (nrise[k] == 0) first[k] = c;
               nrise[k]++; last[k] = c; due[k] = c + 6;
            end
            if (prev[k] && !irq_o[k] && ontime[k]) begin
               n_vec++;
               if (c - last[k] != 6) begin n_err++; $display("FAIL pulse_width: ch %0d got %0d want 6", k, c - last[k]); end
            end
         end
         prev = irq_o;
         fin = 1;
         for (int k = 0; k < N; k++) if (nrise[k] < 4) fin = 0;
         if (fin) break;
      end
      n_vec++; if (!fin) begin n_err++; $display("FAIL pulse_budget: pulses %0d/%0d/%0d want 4 each", nrise[0], nrise[1], nrise[2]); end
      // Seeds ACE1/ACE2/ACE3 give first gaps 226/227/228; arm at 10, load at 11.
      n_vec++; if (first[0] != 237) begin n_err++; $display("FAIL pulse_first0: got %0d want 237", first[0]); end
      n_vec++; if (first[1] != 238) begin n_err++; $display("FAIL pulse_first1: got %0d want 238", first[1]); end
      n_vec++; if (first[2] != 239) begin n_err++; $display("FAIL pulse_first2: got %0d want 239", first[2]); end
   endtask

   task automatic test_verdict(input logic [31:0] x3val);
      int nh, fh, eh;
      logic [31:0] instr_at_first;
      do_reset();
      x3 = x3val;
      nh = 0; fh = -1; eh = -1; instr_at_first = '0;
      for (int c = 1; c <= 200; c++) begin
         rand_bg();
         if (nh < 10 && c > 3 && $urandom_range(0, 5) == 0) begin
            cmt_valid = 1'b1; cmt_pc = PC_TOHOST; nh++;
            if (nh == 1) fh = c;
            if (nh == 8) eh = c;
         end
         step();
         if (c == fh) instr_at_first = instr_cnt;
         n_vec++;
         if ({hits, instr_cnt, end_cycle, cycle_cnt} !== {m_hits, m_instr, m_end, m_cyc})
            begin n_err++; $display("FAIL verdict_cnt: step %0d got h%0d i%0d e%0d c%0d want h%0d i%0d e%0d c%0d",
               c, hits, instr_cnt, end_cycle, cycle_cnt, m_hits, m_instr, m_end, m_cyc); end
         n_vec++;
         if ({done, pass} !== {m_done, m_pass}) begin n_err++; $display("FAIL verdict_flags: step %0d got %b want %b", c, {done, pass}, {m_done, m_pass}); end
         if (eh > 0 && c == eh) begin
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL verdict_early: got done=%b want 0", done); end
         end
         if (eh > 0 && c == eh + 1) begin
            n_vec++; if ({done, pass} !== {1'b1, x3val == 32'd1}) begin n_err++; $display("FAIL verdict_done: got %b want %b", {done, pass}, {1'b1, x3val == 32'd1}); end
         end
      end
      n_vec++; if (eh < 0) begin n_err++; $display("FAIL verdict_hits: got %0d hits want 8", nh); end
      n_vec++; if (end_cycle !== 32'(fh - 1)) begin n_err++; $display("FAIL verdict_endcyc: got %0d want %0d", end_cycle, fh - 1); end
      n_vec++; if (instr_cnt !== instr_at_first) begin n_err++; $display("FAIL verdict_freeze: got %0d want %0d", instr_cnt, instr_at_first); end
   endtask

   task automatic test_timeout();
      int nh;
      do_reset();
      timeout_en = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         rand_bg(); cmt_valid = 1'b0;
         step();
         n_vec++;
         if (timeout !== (c >= 65)) begin n_err++; $display("FAIL timeout_rise: step %0d got %b want %b", c, timeout, c >= 65); end
      end
      nh = 0;
      for (int c = 81; c <= 120; c++) begin
         rand_bg(); cmt_valid = 1'b0;
         if ((c - 81) % 4 == 0 && nh < 8) begin cmt_valid = 1'b1; cmt_pc = PC_TOHOST; nh++; end
         step();
         n_vec++;
         if ({done, timeout} !== 2'b01) begin n_err++; $display("FAIL timeout_block: step %0d got done,to=%b want 01", c, {done, timeout}); end
      end
      n_vec++; if (hits !== 32'd8) begin n_err++; $display("FAIL timeout_hits: got %0d want 8", hits); end
   endtask

   task automatic test_stop_assert();
      int ch, nh, pick;
      do_reset();
      inj_en = 1'b1;
      ch = -1;
      for (int c = 1; c <= 3000 && ch < 0; c++) begin
         rand_bg(); cmt_valid = 1'b0;
         if (c == 3) begin cmt_valid = 1'b1; cmt_pc = PC_ARM; end
         step();
         for (int k = N-1; k >= 0; k--) if (irq_o[k]) ch = k;
      end
      n_vec++; if (ch < 0) begin n_err++; $display("FAIL stop_norise: got none want a rise"); ch = 0; end
      nh = 0;
      for (int c = 0; c < 7; c++) begin
         rand_bg(); cmt_valid = 1'b0;
         if (nh < 3) begin cmt_valid = 1'b1; cmt_pc = PC_TOHOST; nh++; end
         step();
         n_vec++;
         if (irq_o[ch] !== 1'b1) begin n_err++; $display("FAIL stop_hold: ch %0d step %0d got %b want 1", ch, c, irq_o[ch]); end
      end
      rand_bg(); cmt_valid = 1'b1; cmt_pc = ack_pc(ch);
      step();
      n_vec++; if (irq_o[ch] !== 1'b0) begin n_err++; $display("FAIL stop_drop: got %b want 0", irq_o[ch]); end
      for (int c = 0; c < 1500; c++) begin
         rand_bg(); cmt_valid = 1'b0;
         pick = -1;
         for (int k = 0; k < N; k++) if (pick < 0 && irq_o[k]) pick = k;
         if (pick >= 0) begin cmt_valid = 1'b1; cmt_pc = ack_pc(pick); end
         step();
         n_vec++;
         if (irq_o !== m_irq_vec()) begin n_err++; $display("FAIL stop_model: step %0d got %b want %b", c, irq_o, m_irq_vec()); end
         n_vec++;
         if (irq_o[ch] !== 1'b0) begin n_err++; $display("FAIL stop_halt: step %0d got %b want 0", c, irq_o[ch]); end
      end
      n_vec++; if (irq_o !== 3'b000) begin n_err++; $display("FAIL stop_final: got %b want 000", irq_o); end
   endtask

   task automatic test_reset_mid_assert();
      bit rose;
      do_reset();
      inj_en = 1'b1;
      rose = 0;
      for (int c = 1; c <= 3000 && !rose; c++) begin
         rand_bg(); cmt_valid = 1'b0;
         if (c == 2) begin cmt_valid = 1'b1; cmt_pc = PC_ARM; end
         step();
         if (irq_o != '0) rose = 1;
      end
      n_vec++; if (!rose) begin n_err++; $display("FAIL midrst_norise: got none want a rise"); end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (irq_o !== 3'b000) begin n_err++; $display("FAIL midrst_irq: got %b want 000", irq_o); end
      n_vec++; if (cycle_cnt !== 32'd0) begin n_err++; $display("FAIL midrst_cycle: got %0d want 0", cycle_cnt); end
      do_reset();
      inj_en = 1'b1;
      for (int c = 1; c <= 1300; c++) begin
         rand_bg();
         step();
         n_vec++;
         if (irq_o !== 3'b000) begin n_err++; $display("FAIL midrst_rearm: step %0d got %b want 000", c, irq_o); end
      end
   endtask

   initial begin
      test_reset();
      test_no_arm();
      test_pulses();
      test_verdict(32'd1);
      test_verdict(32'd2);
      test_timeout();
      test_stop_assert();
      test_reset_mid_assert();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
